// File: rtl/ciphertext_loader_pkg.sv
// rtl/ciphertext_loader_pkg.sv - shared block geometry, FSM encodings and types
// Common to the loader, its interfaces and the Decoder side of the datapath.
package ciphertext_loader_pkg;

    localparam int BLOCK_W     = 64;
    localparam int BLOCK_BYTES = 8;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef logic [7:0]         byte_t;
    typedef logic [BLOCK_W-1:0] block_t;

endpackage

// File: rtl/ciphertext_loader_if.sv
// rtl/ciphertext_loader_if.sv - byte stream and Decoder handshake interfaces
// The loader is the slave of the byte stream and the master of the Decoder link.
interface ct_byte_if;
    import ciphertext_loader_pkg::*;

    byte_t in_byte;
    logic  in_valid;
    logic  in_ready;

    modport master (output in_byte, output in_valid, input  in_ready);
    modport slave  (input  in_byte, input  in_valid, output in_ready);
endinterface

interface ct_dec_if;
    import ciphertext_loader_pkg::*;

    logic   dec_start;
    block_t dec_ciphertext;
    logic   dec_done;

    modport master (output dec_start, output dec_ciphertext, input  dec_done);
    modport slave  (input  dec_start, input  dec_ciphertext, output dec_done);
endinterface

// File: rtl/ciphertext_loader.sv
// rtl/ciphertext_loader.sv - packs 8 stream bytes MSB-first into a block for the Decoder
// Holds Start until done or watchdog expiry, then waits for done to drop before reloading.
module ciphertext_loader
    import ciphertext_loader_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    ct_byte_if.slave    byte_s,
    ct_dec_if.master    dec_m,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] blocks_done
);

    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]       LAST_BYTE = 3'(BLOCK_BYTES - 1);

    logic [1:0]         state_q, state_d;
    logic [2:0]         byte_cnt_q, byte_cnt_d;
    logic [BLOCK_W-9:0] sr_q, sr_d;
    block_t             ct_q, ct_d;
    logic               start_q, start_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               terr_q, terr_d;
    logic [15:0]        blocks_q, blocks_d;
    logic [CNT_W-1:0]   wd_q, wd_d;

    logic   xfer;
    block_t assembled;

    assign xfer      = ready_q && byte_s.in_valid;
    assign assembled = {sr_q, byte_s.in_byte};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        sr_d       = sr_q;
        ct_d       = ct_q;
        start_d    = start_q;
        blocks_d   = blocks_q;
        wd_d       = wd_q;
        terr_d     = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                if (xfer) begin
                    sr_d       = assembled[BLOCK_W-9:0];
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    // The 8th byte lands straight in the output block, no extra cycle.
                    if (byte_cnt_q == LAST_BYTE) begin
                        ct_d    = assembled;
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                start_d = 1'b1;
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the watchdog's last cycle still counts as success.
                if (dec_m.dec_done) begin
                    start_d  = 1'b0;
                    blocks_d = blocks_q + 16'd1;
                    state_d  = ST_RELEASE;
                end else if (wd_q == WD_LAST) begin
                    start_d = 1'b0;
                    terr_d  = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!dec_m.dec_done) begin
                    state_d = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase

        ready_d = (state_d == ST_COLLECT);
        busy_d  = !ready_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_COLLECT;
            byte_cnt_q <= '0;
            sr_q       <= '0;
            ct_q       <= '0;
            start_q    <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            terr_q     <= 1'b0;
            blocks_q   <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            sr_q       <= sr_d;
            ct_q       <= ct_d;
            start_q    <= start_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            terr_q     <= terr_d;
            blocks_q   <= blocks_d;
            wd_q       <= wd_d;
        end
    end

    assign byte_s.in_ready      = ready_q;
    assign dec_m.dec_start      = start_q;
    assign dec_m.dec_ciphertext = ct_q;
    assign busy                 = busy_q;
    assign timeout_err          = terr_q;
    assign blocks_done          = blocks_q;

endmodule

// File: tb/tb_ciphertext_loader.sv
// tb/tb_ciphertext_loader.sv - randomized and directed bench with a queue-based reference model
module tb_ciphertext_loader;
    import ciphertext_loader_pkg::*;

    localparam int TO = 16;
    localparam logic [63:0] BLK0 = 64'h3cf72a8b7518e6f7;
    localparam logic [63:0] BLK1 = 64'h0123456789abcdef;
    localparam logic [63:0] BLK2 = 64'hfedcba9876543210;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        busy, timeout_err;
    logic [15:0] blocks_done;

    ct_byte_if sif ();
    ct_dec_if  dif ();

    ciphertext_loader #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_s     (sif),
        .dec_m      (dif),
        .busy       (busy),
        .timeout_err(timeout_err),
        .blocks_done(blocks_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int start_cycles = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Reference model: collected bytes in a queue, a pending-start flag, an age
    // counter while Start is high, and a drain flag while done is still held.
    byte_t       m_q[$];
    logic [63:0] m_ct = '0;
    bit          m_ready = 1'b1, m_start = 1'b0, m_terr = 1'b0;
    bit          m_pend = 1'b0, m_drain = 1'b0;
    int          m_age = 0;
    logic [15:0] m_blocks = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_ct = '0; m_ready = 1; m_start = 0; m_terr = 0;
            m_pend = 0; m_drain = 0; m_age = 0; m_blocks = '0;
        end else begin
            m_terr = 0;
            if (m_ready) begin
                if (sif.in_valid) begin
                    m_q.push_back(sif.in_byte);
                    if (m_q.size() == 8) begin
                        m_ct = '0;
                        for (int i = 0; i < 8; i++) m_ct = (m_ct << 8) | 64'(m_q[i]);
                        m_q.delete();
                        m_ready = 0;
                        m_pend = 1;
                    end
                end
            end else if (m_pend) begin
                m_pend = 0; m_start = 1; m_age = 0;
            end else if (m_start) begin
                if (dif.dec_done) begin
                    m_start = 0; m_blocks = m_blocks + 16'd1; m_drain = 1;
                end else if (m_age == TO - 1) begin
                    m_start = 0; m_terr = 1; m_drain = 1;
                end else begin
                    m_age++;
                end
            end else if (m_drain && !dif.dec_done) begin
                m_drain = 0; m_ready = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready", 64'(sif.in_ready), 64'(m_ready));
        check("busy", 64'(busy), 64'(!m_ready));
        check("dec_start", 64'(dif.dec_start), 64'(m_start));
        check("dec_ciphertext", dif.dec_ciphertext, m_ct);
        check("timeout_err", 64'(timeout_err), 64'(m_terr));
        check("blocks_done", 64'(blocks_done), 64'(m_blocks));
        if (dif.dec_start) start_cycles++;
    end

    // Presents one byte starting just after a rising edge and holds it until taken.
    task automatic push_byte(input byte_t b);
        bit acc;
        int n;
        sif.in_valid = 1'b1;
        sif.in_byte  = b;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = sif.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) fail_now("byte_accept");
        sif.in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] blk, input int maxgap);
        logic [63:0] sh;
        sh = blk;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            repeat ((maxgap > 0) ? $urandom_range(0, maxgap) : 0) begin
                @(posedge clk);
                #1;
            end
            push_byte(sh[63:56]);
            sh = sh << 8;
        end
    endtask

    task automatic decode(input int delay, input int hold, input bit never, output int t_to);
        int n;
        t_to = -1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dif.dec_start && n < 600);
        if (!dif.dec_start) begin
            fail_now("start_wait");
            return;
        end
        if (never) begin
            n = 0;
            while (!timeout_err && n < TO + 8) begin
                @(negedge clk);
                n++;
            end
            if (!timeout_err) fail_now("timeout_wait");
            t_to = n;
        end else begin
            repeat (delay) @(posedge clk);
            #1 dif.dec_done = 1'b1;
            repeat (hold) @(posedge clk);
            #1 dif.dec_done = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dif.dec_start && n < TO + 8);
        if (dif.dec_start) fail_now("start_drop");
    endtask

    initial begin
        int          t;
        logic [15:0] b0;
        logic [63:0] rb;
        sif.in_valid = 1'b0;
        sif.in_byte  = '0;
        dif.dec_done = 1'b0;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(sif.in_ready), 64'd1);
        check("rst_dec_start", 64'(dif.dec_start), 64'd0);
        check("rst_blocks", 64'(blocks_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Back-to-back block, done pulse 5 cycles after Start
        start_cycles = 0;
        fork
            send_block(BLK0, 0);
            decode(5, 1, 1'b0, t);
        join
        check("t2_ct", dif.dec_ciphertext, BLK0);
        check("t2_start_cycles", 64'(start_cycles), 64'd6);
        check("t2_blocks", 64'(blocks_done), 64'd1);
        check("t2_release_ready", 64'(sif.in_ready), 64'd0);
        @(negedge clk);
        check("t2_ready_back", 64'(sif.in_ready), 64'd1);

        // Gappy bytes, then the next block's first byte stalls through WAIT
        fork
            begin
                send_block(BLK0, 2);
                send_block(BLK0, 0);
            end
            begin
                decode(8, 1, 1'b0, t);
                decode(3, 1, 1'b0, t);
            end
        join
        check("t3_ct", dif.dec_ciphertext, BLK0);
        check("t3_blocks", 64'(blocks_done), 64'd3);

        // Decoder never answers
        b0 = blocks_done;
        fork
            send_block(BLK1, 0);
            decode(0, 0, 1'b1, t);
        join
        check("t4_timeout_ofs", 64'(t), 64'(TO));
        check("t4_blocks", 64'(blocks_done), 64'(b0));
        @(negedge clk);
        check("t4_ready_back", 64'(sif.in_ready), 64'd1);

        // Done held for 10 cycles
        b0 = blocks_done;
        fork
            send_block(BLK2, 1);
            decode(2, 10, 1'b0, t);
        join
        repeat (3) @(negedge clk);
        check("t5_blocks", 64'(blocks_done), 64'(b0 + 16'd1));

        // Reset after 4 bytes
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push_byte(byte_t'(8'h90 + i));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_rst_ready", 64'(sif.in_ready), 64'd1);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_ct", dif.dec_ciphertext, 64'd0);
        check("t6_rst_blocks", 64'(blocks_done), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        fork
            send_block(BLK2, 0);
            decode(1, 1, 1'b0, t);
        join
        check("t6_clean_ct", dif.dec_ciphertext, BLK2);
        check("t6_clean_blocks", 64'(blocks_done), 64'd1);

        // Reset while the Decoder is working
        fork
            send_block(BLK1, 0);
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!dif.dec_start && n < 600);
                if (!dif.dec_start) fail_now("t6_start_wait");
            end
        join
        #1 reset = 1'b0;
        #1;
        check("t6_wait_rst_start", 64'(dif.dec_start), 64'd0);
        check("t6_wait_rst_busy", 64'(busy), 64'd0);
        #1 reset = 1'b1;

        // Randomized traffic: source and Decoder run independently
        fork
            for (int k = 0; k < 30; k++) begin
                rb = {$urandom, $urandom};
                send_block(rb, 3);
            end
            for (int k = 0; k < 30; k++) begin
                decode($urandom_range(0, 20), $urandom_range(1, 4), ($urandom_range(0, 6) == 0), t);
            end
        join
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
